fetch_fifo_consumer_chk: RTL and testbench
==========================================

// Module: fetch_fifo_consumer_chk
// PURPOSE
//  Consumer/checker for the output end of the instruction fetch FIFO. Drives out_ready_o, snoops
//  the FIFO input stream into a halfword shadow queue, and checks every out handshake (addr, rdata,
//  err, err_plus2) against it. Synthesizable; sits beside the DUT in the FIFO test harness.
// PARAMETERS
//  SHADOW_HW  16        shadow queue depth in halfwords (power of 2, >= 8)
//  READY_MODE 0         0: out_ready_o always 1; 1: out_ready_o = LFSR-driven pseudo-random
//  LFSR_SEED  16'hACE1  reset value of the 16-bit ready LFSR (must be non-zero)
//  CNT_W      16        width of chk_count_o
// PORTS
//  clk_i            in   1      clock
//  rst_ni           in   1      asynchronous active-low reset
//  clear_i          in   1      FIFO clear (snooped)
//  in_valid_i       in   1      FIFO input valid (snooped)
//  in_addr_i        in   32     FIFO input fetch address (snooped)
//  in_rdata_i       in   32     FIFO input fetch word (snooped)
//  in_err_i         in   1      FIFO input bus error (snooped)
//  out_valid_i      in   1      FIFO output valid
//  out_addr_i       in   32     FIFO output instruction address
//  out_rdata_i      in   32     FIFO output instruction
//  out_err_i        in   1      FIFO output error
//  out_err_plus2_i  in   1      FIFO output error on second halfword
//  out_ready_o      out  1      consumer ready
//  chk_error_o      out  1      sticky: any mismatch / underflow
//  overflow_o       out  1      sticky: shadow queue overflow
//  chk_count_o      out  CNT_W  checked handshakes, saturating
// BEHAVIOUR
//  Reset: out_ready_o=0, chk_error_o=0, overflow_o=0, chk_count_o=0, shadow empty, LFSR=LFSR_SEED,
//   start_pending=1. out_ready_o is registered: READY_MODE 0 -> 1 from first cycle after reset;
//   mode 1 -> LFSR[0], LFSR (taps 16,14,13,11) advances every cycle.
//  Push: in_valid_i & ~clear_i. If start_pending: exp_addr<=in_addr_i, start_pending<=0, and
//   in_addr_i[1]=1 pushes only upper halfword. Else both halfwords, low first. Entry = {data16, err}.
//   Push with free < halfwords pushed -> push dropped, overflow_o<=1.
//  Clear: clear_i flushes shadow, sets start_pending; same-cycle in_valid_i is discarded; a
//   same-cycle out handshake is neither checked nor counted.
//  Check on fire = out_valid_i & out_ready_o & ~clear_i. h0 = head entry; is32 = h0.data[1:0]==2'b11.
//   Need = is32 ? 2 : 1 entries; fewer present (incl. same-cycle push, which is NOT visible) ->
//   chk_error_o<=1, no pop.
//   exp_err = h0.err | (is32 & h1.err); exp_plus2 = is32 & ~h0.err & h1.err.
//   Always compare out_addr_i==exp_addr, out_err_i==exp_err, out_err_plus2_i==exp_plus2.
//   If ~exp_err: compare out_rdata_i[15:0]==h0.data, and if is32 also [31:16]==h1.data.
//   Any mismatch -> chk_error_o<=1 the cycle after fire (sticky until reset).
//   Pop need entries; exp_addr <= exp_addr + (is32 ? 4 : 2), 32-bit wrap; chk_count_o++ (sat).
//  Simultaneous push+pop: both apply; occupancy = occ + pushed - popped; pointers wrap mod SHADOW_HW.
//  out_valid_i without out_ready_o: no check; holding stable not checked here (assertion's job).
//  Reset mid-stream: all state to reset values immediately (async), no check of in-flight beat.
// STRUCTURE
//  Package fetch_chk_pkg: typedef shadow_entry_t {logic [15:0] data; logic err;}, LFSR taps constant,
//   helper function is_compressed(logic [15:0]).
//  Sub-module fetch_ready_gen: LFSR + READY_MODE mux, output registered out_ready_o.
//  Top: shadow RAM (flop array), rd/wr pointers, occupancy counter, exp_addr, compare logic.
// TESTING
//  1 Reset, READY_MODE 0, push addr 0x100 rdata 0x0001_4501 -> two 16b checks addr 0x100,0x102,
//    chk_count_o=2, chk_error_o=0.
//  2 Push 0x200 rdata 0x1234_0013, then 0x204 0x0000_5678 -> 32b @0x200 rdata 0x1234_0013, then 16b
//    @0x204; corrupt out_addr to 0x202 on 2nd -> chk_error_o=1 next cycle.
//  3 Unaligned start 0x302 rdata 0x0093_xxxx, next 0x304 rdata 0xABCD_0000 in_err=1 -> 32b @0x302,
//    out_err=1, out_err_plus2=1 expected; err_plus2=0 from DUT -> chk_error_o=1.
//  4 Fill shadow with SHADOW_HW/2 words, no pops, one more push -> overflow_o=1, count unchanged.
//  5 clear_i with in_valid_i and out fire same cycle -> shadow empty, count unchanged; next push
//    at 0x402 starts new stream at 0x402.
//  6 READY_MODE 1, 1000 random words, all halfwords 16b/32b mixed -> out_ready_o toggles,
//    chk_error_o=0, chk_count_o equals instruction count; rst_ni low mid-run -> all outputs 0.

Source files
------------

// File: rtl/fetch_chk_pkg.sv
// Shared types and helpers for the fetch FIFO consumer/checker.
// Shadow entries are one halfword plus its bus-error flag.
package fetch_chk_pkg;

   typedef struct packed {
      logic [15:0] data;
      logic        err;
   } shadow_entry_t;

   // Feedback taps 16,14,13,11 of the ready LFSR
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic is_compressed(logic [15:0] hw);
      return hw[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/fetch_ready_gen.sv
// Ready generator: constant or LFSR-driven registered out_ready_o.
// Ports: clk_i, rst_ni (async, active low), out_ready_o.
module fetch_ready_gen
   import fetch_chk_pkg::*;
#(
   parameter int          READY_MODE = 0,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic out_ready_o
);

   logic [15:0] lfsr_q;
   logic        fb;

   assign fb = ^(lfsr_q & LFSR_TAPS);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q      <= LFSR_SEED;
         out_ready_o <= 1'b0;
      end else begin
         lfsr_q      <= {lfsr_q[14:0], fb};
         out_ready_o <= (READY_MODE != 0) ? lfsr_q[0] : 1'b1;
      end
   end

endmodule

// File: rtl/fetch_fifo_consumer_chk.sv
// Consumer/checker for the fetch FIFO output; snoops the input stream
// into a halfword shadow queue and checks every out handshake against it.
// Ports: clk_i, rst_ni, clear_i, in_* (snooped FIFO input), out_* (FIFO
// output), out_ready_o, chk_error_o / overflow_o (sticky), chk_count_o.
module fetch_fifo_consumer_chk
   import fetch_chk_pkg::*;
#(
   parameter int unsigned SHADOW_HW  = 16,
   parameter int          READY_MODE = 0,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             in_valid_i,
   input  logic [31:0]      in_addr_i,
   input  logic [31:0]      in_rdata_i,
   input  logic             in_err_i,
   input  logic             out_valid_i,
   input  logic [31:0]      out_addr_i,
   input  logic [31:0]      out_rdata_i,
   input  logic             out_err_i,
   input  logic             out_err_plus2_i,
   output logic             out_ready_o,
   output logic             chk_error_o,
   output logic             overflow_o,
   output logic [CNT_W-1:0] chk_count_o
);

   localparam int unsigned AW = $clog2(SHADOW_HW);
   localparam logic [AW:0] DEPTH = (AW+1)'(SHADOW_HW);

   shadow_entry_t mem_q [SHADOW_HW];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [AW:0]   occ_q;
   logic [31:0]   exp_addr_q;
   logic          start_pend_q;

   logic          push_req, push_one, push_ok;
   logic [AW:0]   n_push, n_pop, need, free;
   shadow_entry_t h0, h1, lo_e, hi_e;
   logic          fire, is32, avail, pop;
   logic          exp_err, exp_p2, mism;

   fetch_ready_gen #(
      .READY_MODE (READY_MODE),
      .LFSR_SEED  (LFSR_SEED)
   ) u_ready (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .out_ready_o (out_ready_o)
   );

   // An unaligned first fetch carries only its upper halfword
   assign push_req = in_valid_i & ~clear_i;
   assign push_one = start_pend_q & in_addr_i[1];
   assign n_push   = push_one ? (AW+1)'(1) : (AW+1)'(2);
   assign free     = DEPTH - occ_q;
   assign push_ok  = push_req & (free >= n_push);
   assign lo_e     = '{data: in_rdata_i[15:0], err: in_err_i};
   assign hi_e     = '{data: in_rdata_i[31:16], err: in_err_i};

   assign h0      = mem_q[rd_ptr_q];
   assign h1      = mem_q[rd_ptr_q + AW'(1)];
   assign is32    = ~is_compressed(h0.data);
   assign need    = is32 ? (AW+1)'(2) : (AW+1)'(1);
   assign fire    = out_valid_i & out_ready_o & ~clear_i;
   assign avail   = occ_q >= need;
   assign pop     = fire & avail;
   assign n_pop   = pop ? need : '0;
   assign exp_err = h0.err | (is32 & h1.err);
   assign exp_p2  = is32 & ~h0.err & h1.err;

   // Instruction bits are meaningless once the fetch faulted
   always_comb begin
      mism = (out_addr_i != exp_addr_q) |
             (out_err_i != exp_err) |
             (out_err_plus2_i != exp_p2);
      if (!exp_err) begin
         mism = mism | (out_rdata_i[15:0] != h0.data);
         if (is32) mism = mism | (out_rdata_i[31:16] != h1.data);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         if (push_one) begin
            mem_q[wr_ptr_q] <= hi_e;
         end else begin
            mem_q[wr_ptr_q]          <= lo_e;
            mem_q[wr_ptr_q + AW'(1)] <= hi_e;
         end
      end
   end

   // exp_addr is loaded by a stream-start push only while the
   // shadow is empty, so it never collides with a pop update.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         occ_q        <= '0;
         exp_addr_q   <= '0;
         start_pend_q <= 1'b1;
         chk_error_o  <= 1'b0;
         overflow_o   <= 1'b0;
         chk_count_o  <= '0;
      end else if (clear_i) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         occ_q        <= '0;
         start_pend_q <= 1'b1;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + n_push[AW-1:0];
            if (start_pend_q) begin
               exp_addr_q   <= in_addr_i;
               start_pend_q <= 1'b0;
            end
         end
         if (push_req && !push_ok) overflow_o <= 1'b1;
         if (fire && (!avail || mism)) chk_error_o <= 1'b1;
         if (pop) begin
            rd_ptr_q   <= rd_ptr_q + n_pop[AW-1:0];
            exp_addr_q <= exp_addr_q + (is32 ? 32'd4 : 32'd2);
            if (chk_count_o != {CNT_W{1'b1}})
               chk_count_o <= chk_count_o + CNT_W'(1);
         end
         occ_q <= occ_q + (push_ok ? n_push : '0) - n_pop;
      end
   end

endmodule

// File: tb/tb_fetch_fifo_consumer_chk.sv
// Scoreboard bench for fetch_fifo_consumer_chk: a queue-based model of
// the shadow stream predicts chk_error/overflow/count every cycle.
module tb_fetch_fifo_consumer_chk;

   localparam int HW = 16;
   localparam logic [31:0] BASE = 32'h1000;

   typedef struct packed {
      logic        clear;
      logic        in_valid;
      logic [31:0] in_addr;
      logic [31:0] in_rdata;
      logic        in_err;
      logic        out_valid;
      logic [31:0] out_addr;
      logic [31:0] out_rdata;
      logic        out_err;
      logic        out_p2;
   } stim_t;

   typedef struct {
      logic [15:0] d;
      logic        e;
   } hw_t;

   typedef struct {
      int tag;
      bit sel;
      bit err;
      bit ovf;
      int cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   stim_t       s0 = '0, s1 = '0;
   logic        rdy0, err0, ovf0, rdy1, err1, ovf1;
   logic [15:0] cnt0, cnt1;
   int          cyc = 0;
   int          n_checks = 0, n_errors = 0;
   int          n_rdy0 = 0, n_rdy1 = 0;
   bit          sel = 1'b0;
   exp_t        exp_q[$];
   exp_t        me;

   hw_t         mq[$];
   logic [31:0] m_ea;
   bit          m_sp, m_err, m_ovf;
   int          m_cnt;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fetch_fifo_consumer_chk #(
      .SHADOW_HW(HW), .READY_MODE(0), .LFSR_SEED(16'hACE1), .CNT_W(16)
   ) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(s0.clear),
      .in_valid_i(s0.in_valid), .in_addr_i(s0.in_addr),
      .in_rdata_i(s0.in_rdata), .in_err_i(s0.in_err),
      .out_valid_i(s0.out_valid), .out_addr_i(s0.out_addr),
      .out_rdata_i(s0.out_rdata), .out_err_i(s0.out_err),
      .out_err_plus2_i(s0.out_p2), .out_ready_o(rdy0),
      .chk_error_o(err0), .overflow_o(ovf0), .chk_count_o(cnt0)
   );

   fetch_fifo_consumer_chk #(
      .SHADOW_HW(HW), .READY_MODE(1), .LFSR_SEED(16'hACE1), .CNT_W(16)
   ) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(s1.clear),
      .in_valid_i(s1.in_valid), .in_addr_i(s1.in_addr),
      .in_rdata_i(s1.in_rdata), .in_err_i(s1.in_err),
      .out_valid_i(s1.out_valid), .out_addr_i(s1.out_addr),
      .out_rdata_i(s1.out_rdata), .out_err_i(s1.out_err),
      .out_err_plus2_i(s1.out_p2), .out_ready_o(rdy1),
      .chk_error_o(err1), .overflow_o(ovf1), .chk_count_o(cnt1)
   );

   task automatic chk(string nm, longint act, longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      m_ea  = '0;
      m_sp  = 1'b1;
      m_err = 1'b0;
      m_ovf = 1'b0;
      m_cnt = 0;
   endfunction

   // Checking sees the shadow as it was before this cycle's push.
   task automatic model_step(stim_t s, logic r);
      int npop, n;
      bit is32, xe, xp, bad;
      npop = 0;
      if (s.clear) begin
         mq.delete();
         m_sp = 1'b1;
         return;
      end
      if (s.out_valid && r) begin
         is32 = mq.size() > 0 && mq[0].d[1:0] == 2'b11;
         n = is32 ? 2 : 1;
         if (mq.size() < n) begin
            m_err = 1'b1;
         end else begin
            xe = mq[0].e || (is32 && mq[1].e);
            xp = is32 && !mq[0].e && mq[1].e;
            bad = s.out_addr != m_ea || s.out_err != xe || s.out_p2 != xp;
            if (!xe && s.out_rdata[15:0] != mq[0].d) bad = 1'b1;
            if (!xe && is32 && s.out_rdata[31:16] != mq[1].d) bad = 1'b1;
            if (bad) m_err = 1'b1;
            npop = n;
            m_ea = m_ea + (is32 ? 32'd4 : 32'd2);
            if (m_cnt < 65535) m_cnt++;
         end
      end
      if (s.in_valid) begin
         n = (m_sp && s.in_addr[1]) ? 1 : 2;
         if (HW - mq.size() < n) begin
            m_ovf = 1'b1;
         end else begin
            if (n == 2) mq.push_back('{s.in_rdata[15:0], s.in_err});
            mq.push_back('{s.in_rdata[31:16], s.in_err});
            if (m_sp) begin
               m_ea = s.in_addr;
               m_sp = 1'b0;
            end
         end
      end
      repeat (npop) void'(mq.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(stim_t s);
      exp_t e;
      logic r;
      if (sel) s1 = s;
      else s0 = s;
      r = sel ? rdy1 : rdy0;
      if (!sel) chk("ready_mode0", rdy0, 1);
      else if (rdy1) n_rdy1++;
      else n_rdy0++;
      model_step(s, r);
      e.tag = cyc;
      e.sel = sel;
      e.err = m_err;
      e.ovf = m_ovf;
      e.cnt = m_cnt;
      exp_q.push_back(e);
   endtask

   task automatic step(stim_t s);
      tick();
      apply(s);
   endtask

   task automatic do_reset(bit mid);
      if (!mid) begin
         tick();
         s0 = '0;
         s1 = '0;
      end
      #4;
      rst_n = 1'b0;
      exp_q.delete();
      s0 = '0;
      s1 = '0;
      #1;
      chk("rst_ready", sel ? rdy1 : rdy0, 0);
      chk("rst_error", sel ? err1 : err0, 0);
      chk("rst_overflow", sel ? ovf1 : ovf0, 0);
      chk("rst_count", sel ? cnt1 : cnt0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      model_reset();
   endtask

   function automatic stim_t mk_push(logic [31:0] a, logic [31:0] d,
                                     logic e);
      stim_t s;
      s = '0;
      s.in_valid = 1'b1;
      s.in_addr  = a;
      s.in_rdata = d;
      s.in_err   = e;
      return s;
   endfunction

   function automatic stim_t mk_beat(logic [31:0] a, logic [31:0] d,
                                     logic e, logic p2);
      stim_t s;
      s = '0;
      s.out_valid = 1'b1;
      s.out_addr  = a;
      s.out_rdata = d;
      s.out_err   = e;
      s.out_p2    = p2;
      return s;
   endfunction

   // Scoreboard monitor: each cycle's expectation is checked once the
   // edge that applies it has passed.
   initial forever begin
      @(posedge clk);
      #3;
      while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
         me = exp_q.pop_front();
         chk("chk_error", me.sel ? err1 : err0, me.err);
         chk("overflow", me.sel ? ovf1 : ovf0, me.ovf);
         chk("chk_count", me.sel ? cnt1 : cnt0, me.cnt);
      end
   end

   task automatic run_random();
      logic [15:0] hws[$];
      int          ist[$], ilen[$];
      logic [15:0] h;
      int          wp, hp, j, budget;
      bit          act;
      logic [31:0] b_addr, b_data;
      stim_t       s;
      while (hws.size() < 2000) begin
         ist.push_back(hws.size());
         h = 16'($urandom);
         if ($urandom_range(0, 1) == 0 || hws.size() == 1999) begin
            h[1:0] = 2'($urandom_range(0, 2));
            hws.push_back(h);
            ilen.push_back(1);
         end else begin
            h[1:0] = 2'b11;
            hws.push_back(h);
            hws.push_back(16'($urandom));
            ilen.push_back(2);
         end
      end
      wp = 0; hp = 0; j = 0; budget = 0; act = 1'b0;
      b_addr = '0; b_data = '0;
      while (j < ist.size() && budget < 20000) begin
         budget++;
         s = '0;
         tick();
         if (!act && (ist[j] + ilen[j] - 1) / 2 < wp &&
             $urandom_range(0, 3) != 0) begin
            act = 1'b1;
            b_addr = BASE + 32'(2 * ist[j]);
            if (ilen[j] == 2) b_data = {hws[ist[j]+1], hws[ist[j]]};
            else b_data = {16'($urandom), hws[ist[j]]};
         end
         if (act) begin
            s.out_valid = 1'b1;
            s.out_addr  = b_addr;
            s.out_rdata = b_data;
         end
         if (wp < 1000 && wp * 2 - hp <= HW - 2 &&
             $urandom_range(0, 3) != 0) begin
            s.in_valid = 1'b1;
            s.in_addr  = BASE + 32'(4 * wp);
            s.in_rdata = {hws[2*wp+1], hws[2*wp]};
            wp++;
         end
         if (act && rdy1) begin
            hp += ilen[j];
            j++;
            act = 1'b0;
         end
         apply(s);
      end
      if (j < ist.size()) chk("stream_timeout", j, ist.size());
      step('0);
      step('0);
      chk("t6_count", cnt1, ist.size());
      chk("t6_error", err1, 0);
      chk("t6_ready_hi_seen", n_rdy1 > 0, 1);
      chk("t6_ready_lo_seen", n_rdy0 > 0, 1);
   endtask

   initial begin
      stim_t s;
      #3000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d",
               n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s;
      sel = 1'b0;
      do_reset(1'b1);

      // 1: two compressed instructions from one word
      step(mk_push(32'h100, 32'h0001_4501, 1'b0));
      step(mk_beat(32'h100, 32'hDEAD_4501, 1'b0, 1'b0));
      step(mk_beat(32'h102, 32'h0000_0001, 1'b0, 1'b0));
      step('0);
      chk("t1_count", cnt0, 2);
      chk("t1_error", err0, 0);

      // 2: 32b then 16b, second beat has a corrupt address
      do_reset(1'b0);
      step(mk_push(32'h200, 32'h1234_0013, 1'b0));
      step(stim_t'(mk_push(32'h204, 32'h0000_5678, 1'b0) |
                   mk_beat(32'h200, 32'h1234_0013, 1'b0, 1'b0)));
      step(mk_beat(32'h202, 32'h0000_5678, 1'b0, 1'b0));
      chk("t2_err_before", err0, 0);
      chk("t2_count_before", cnt0, 1);
      step('0);
      chk("t2_err_after", err0, 1);

      // 3: unaligned start, fault on second halfword of a 32b insn
      do_reset(1'b0);
      step(mk_push(32'h302, 32'h0093_1111, 1'b0));
      step(mk_push(32'h304, 32'hABCD_0000, 1'b1));
      step(mk_beat(32'h302, 32'h0000_0093, 1'b1, 1'b1));
      step('0);
      chk("t3_good_err", err0, 0);
      chk("t3_good_count", cnt0, 1);
      do_reset(1'b0);
      step(mk_push(32'h302, 32'h0093_1111, 1'b0));
      step(mk_push(32'h304, 32'hABCD_0000, 1'b1));
      step(mk_beat(32'h302, 32'h0000_0093, 1'b1, 1'b0));
      step('0);
      chk("t3_bad_err", err0, 1);

      // 4: overflow of the shadow queue
      do_reset(1'b0);
      for (int i = 0; i < HW / 2; i++)
         step(mk_push(32'h500 + 32'(4 * i),
                      {16'(i * 8 + 4), 16'(i * 8)}, 1'b0));
      step(mk_push(32'h520, 32'h0000_0000, 1'b0));
      chk("t4_ovf_before", ovf0, 0);
      step(mk_beat(32'h500, 32'h0004_0000, 1'b0, 1'b0));
      chk("t4_ovf_after", ovf0, 1);
      chk("t4_count", cnt0, 0);
      step('0);
      chk("t4_count_pop", cnt0, 1);
      chk("t4_err", err0, 0);

      // 5: clear with same-cycle push and fire, then a new stream
      do_reset(1'b0);
      step(mk_push(32'h600, 32'h0001_0001, 1'b0));
      s = stim_t'(mk_push(32'h700, 32'h5555_5555, 1'b0) |
                  mk_beat(32'h600, 32'h0000_0001, 1'b0, 1'b0));
      s.clear = 1'b1;
      step(s);
      step(mk_push(32'h402, 32'h0005_9999, 1'b0));
      chk("t5_count_clear", cnt0, 0);
      step(mk_beat(32'h402, 32'h0000_0005, 1'b0, 1'b0));
      step('0);
      chk("t5_count", cnt0, 1);
      chk("t5_err", err0, 0);

      // 6: random mixed stream with pseudo-random ready
      sel = 1'b1;
      do_reset(1'b0);
      run_random();
      step(mk_push(32'h2000, 32'h0001_0001, 1'b0));
      step(stim_t'(mk_push(32'h2004, 32'h0001_0001, 1'b0) |
                   mk_beat(32'h2000, 32'h0000_0001, 1'b0, 1'b0)));
      do_reset(1'b1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
